// File: rtl/fpa_rr_arbiter_pkg.sv
// fpa_rr_arbiter_pkg: shared state encodings, status codes and widths for the FPA arbiter
package fpa_rr_arbiter_pkg;
  localparam int FP_DW = 32;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;
  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_EXC = 2'b01,
    ST_TMO = 2'b10
  } status_e;
endpackage

// File: rtl/fpa_rr_arbiter_rr_pick.sv
// fpa_rr_arbiter_rr_pick: first set request at or above ptr, wrapping, as one-hot plus index
module fpa_rr_arbiter_rr_pick
  import fpa_rr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);
  // scan NREQ positions starting at ptr; the first hit wins
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[(int'(ptr) + k) % NREQ]) begin
        grant[(int'(ptr) + k) % NREQ] = 1'b1;
        idx = IW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fpa_rr_arbiter.sv
// fpa_rr_arbiter: round-robin sharing of one floating-point adder among NREQ requesters
module fpa_rr_arbiter
  import fpa_rr_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = FP_DW,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 fpa_start,
  output logic [DW-1:0]        fpa_a,
  output logic [DW-1:0]        fpa_b,
  input  logic                 fpa_done,
  input  logic                 fpa_except,
  input  logic [DW-1:0]        fpa_result,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic [1:0]           rsp_status,
  output logic                 busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e          state_q, state_d;
  status_e         rsp_status_q, rsp_status_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d, win;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   fpa_a_q, fpa_a_d, fpa_b_q, fpa_b_d, rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d, grant;
  logic            fpa_start_q, fpa_start_d, any;
  fpa_rr_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );
  // grant is offered only while idle, and never while reset is held
  assign req_ready  = (state_q == S_IDLE && !clr) ? grant : '0;
  assign fpa_start  = fpa_start_q;
  assign fpa_a      = fpa_a_q;
  assign fpa_b      = fpa_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign busy       = state_q != S_IDLE;
  // next-state: accept, pulse start, wait for done/except/timeout, strobe the owner
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    fpa_a_d      = fpa_a_q;
    fpa_b_d      = fpa_b_q;
    fpa_start_d  = 1'b0;
    rsp_valid_d  = '0;
    rsp_data_d   = '0;
    rsp_status_d = ST_OK;
    unique case (state_q)
      S_IDLE: if (any) begin
        state_d     = S_ISSUE;
        owner_d     = win;
        rr_ptr_d    = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
        fpa_a_d     = req_a[win*DW +: DW];
        fpa_b_d     = req_b[win*DW +: DW];
        fpa_start_d = 1'b1;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (fpa_except || fpa_done || cnt_q == CW'(TIMEOUT - 1)) begin
          state_d      = S_RESP;
          rsp_valid_d  = NREQ'(1) << owner_q;
          rsp_data_d   = (!fpa_except && fpa_done) ? fpa_result : '0;
          rsp_status_d = fpa_except ? ST_EXC : (fpa_done ? ST_OK : ST_TMO);
        end
      end
      S_RESP: state_d = S_IDLE;
    endcase
  end
  // state and registered outputs; reset drops any in-flight operation silently
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      fpa_a_q      <= '0;
      fpa_b_q      <= '0;
      fpa_start_q  <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      fpa_a_q      <= fpa_a_d;
      fpa_b_q      <= fpa_b_d;
      fpa_start_q  <= fpa_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end
endmodule
